// File: rtl/chip8_rom_loader_if.sv
// Host byte stream and program-memory write port of the CHIP-8 ROM loader.
// master: host/memory side; slave: loader (in_ready, mem_we/addr/wdata out).
interface chip8_rom_loader_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/chip8_rom_loader.sv
// CHIP-8 program loader: framed bytes (LEN_HI, LEN_LO, N bytes, CSUM) to memory.
// Ports: clk, rst_n, start, bus (slave), cpu_hold, done, error.
module chip8_rom_loader #(
    parameter int ADDR_W    = 12,
    parameter int MEM_BYTES = 3328,
    parameter int BASE_ADDR = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    chip8_rom_loader_if.slave bus,
    output logic cpu_hold,
    output logic done,
    output logic error
);
    typedef enum logic [2:0] {
        IDLE, S_LENH, S_LENL, S_DATA, S_CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] LIMIT = 17'(MEM_BYTES - BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [15:0] count;
    logic [7:0]  sum;
    logic        fire;
    logic [15:0] n_full;

    assign fire   = bus.in_valid & bus.in_ready;
    // Length as it will be once the LEN_LO byte lands.
    assign n_full = {len[15:8], bus.in_data};

    assign bus.in_ready = (state == S_LENH) || (state == S_LENL) ||
                          (state == S_DATA) || (state == S_CSUM);
    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = S_LENH;
            end
            S_LENH: begin
                if (fire) state_nxt = S_LENL;
            end
            S_LENL: begin
                if (fire) begin
                    if (n_full == 16'd0 || {1'b0, n_full} > LIMIT)
                        state_nxt = ERR;
                    else
                        state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (fire && count == len - 16'd1) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (fire) state_nxt = (bus.in_data == sum) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len           <= '0;
            count         <= '0;
            sum           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (fire) begin
                unique case (state)
                    S_LENH: len[15:8] <= bus.in_data;
                    S_LENL: begin
                        len[7:0] <= bus.in_data;
                        count    <= '0;
                        sum      <= '0;
                    end
                    S_DATA: begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= BASE + count[ADDR_W-1:0];
                        bus.mem_wdata <= bus.in_data;
                        count         <= count + 16'd1;
                        sum           <= sum + bus.in_data;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_chip8_rom_loader.sv
// Testbench for chip8_rom_loader: directed frames with a write scoreboard.
// Expected writes are queued when payload is driven and popped on mem_we.
module tb_chip8_rom_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    always #5 clk = ~clk;

    chip8_rom_loader_if #(.ADDR_W(12)) bus ();

    chip8_rom_loader #(
        .ADDR_W(12), .MEM_BYTES(3328), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    int          checks = 0;
    int          failures = 0;
    int          wr_count = 0;
    logic [11:0] last_addr = '0;
    logic [19:0] exp_q[$];
    logic [7:0]  payload [3328];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) begin
            logic [19:0] e;
            wr_count++;
            last_addr = bus.mem_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_we", {20'd0, bus.mem_addr}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {20'd0, bus.mem_addr}, {20'd0, e[19:8]});
                check("wr_data", {24'd0, bus.mem_wdata}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit hs;
        int n;
        if (max_gap > 0) begin
            repeat ($urandom_range(0, max_gap)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            hs = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!hs) check("handshake_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] csum_xor,
                              input int max_gap, input int start_at);
        logic [7:0]  s;
        logic [15:0] nn;
        s  = 8'd0;
        nn = 16'(n);
        wr_count = 0;
        send_byte(nn[15:8], max_gap);
        send_byte(nn[7:0], max_gap);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({12'(i), payload[i]});
            s = s + payload[i];
            if (i == start_at) start = 1'b1;
            send_byte(payload[i], (i == start_at) ? 0 : max_gap);
            start = 1'b0;
        end
        send_byte(s ^ csum_xor, max_gap);
    endtask

    task automatic finish_frame(input int n);
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("write_count", wr_count, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        for (int i = 0; i < 3328; i++) payload[i] = 8'($urandom);
        payload[0] = 8'hA2;
        payload[1] = 8'h1E;
        payload[2] = 8'h60;
        payload[3] = 8'h05;

        #2;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) begin
            check("idle_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("idle_no_write", wr_count, 0);

        pulse_start();
        check("lenh_ready", bus.in_ready, 1);
        check("lenh_hold", cpu_hold, 1);
        send_frame(4, 8'h00, 0, -1);
        check("t1_done", done, 1);
        check("t1_hold", cpu_hold, 0);
        check("t1_error", error, 0);
        check("t1_ready", bus.in_ready, 0);
        finish_frame(4);

        pulse_start();
        check("restart_done", done, 0);
        check("restart_hold", cpu_hold, 1);
        send_frame(4, 8'h01, 0, -1);
        check("t2_error", error, 1);
        check("t2_hold", cpu_hold, 1);
        check("t2_done", done, 0);
        check("t2_ready", bus.in_ready, 0);
        finish_frame(4);
        pulse_start();
        check("err_clear", error, 0);
        send_frame(4, 8'h00, 0, -1);
        check("t2_reload_done", done, 1);
        finish_frame(4);

        pulse_start();
        wr_count = 0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("len0_error", error, 1);
        check("len0_ready", bus.in_ready, 0);
        pulse_start();
        send_byte(8'h0D, 0);
        send_byte(8'h01, 0);
        check("len3329_error", error, 1);
        finish_frame(0);

        pulse_start();
        send_frame(3328, 8'h00, 2, -1);
        check("full_done", done, 1);
        finish_frame(3328);
        check("full_last_addr", last_addr, 12'd3327);

        pulse_start();
        send_frame(8, 8'h00, 0, 3);
        check("start_ignored_done", done, 1);
        finish_frame(8);

        pulse_start();
        wr_count = 0;
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        exp_q.push_back({12'd0, payload[0]});
        send_byte(payload[0], 0);
        send_byte(payload[1], 0);
        rst_n = 1'b0;
        #1;
        check("arst_mem_we", bus.mem_we, 0);
        check("arst_hold", cpu_hold, 1);
        check("arst_ready", bus.in_ready, 0);
        check("arst_addr", bus.mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_queue", exp_q.size(), 0);
        check("arst_writes", wr_count, 1);
        pulse_start();
        send_frame(16, 8'h00, 1, -1);
        check("post_rst_done", done, 1);
        finish_frame(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
